lb_reg_array: RTL and testbench
===============================

Name: lb_reg_array

Overview:
Parametrised bank of CH_N identical-width control/status registers on the local bus. It supersedes hand-instantiated single registers in the generated register maps. Each channel has a selectable write mode, a hardware update port, a write lock, and access strobes. The read path is pipelined with a configurable latency. It sits directly behind the APB-to-local-bus bridge and uses the same lb_* handshake.

Parameters:
ADDR_W, 16, local bus address width
DATA_W, 32, register/data width; multiple of 8
CH_N, 4, number of channels (1..64)
BASE_ADDR, 0, byte address of channel 0
STRIDE, 4, byte stride between channels; power of two, >= DATA_W/8
MODE, 0, packed 3*CH_N bits, 3 bits per channel: 0=RW, 1=W1C, 2=W1S, 3=W1T, 4=RC (RW + clear-on-read); other codes behave as RW
RESET_VAL, 0, packed CH_N*DATA_W reset values
READ_LAT, 1, lb_ren to lb_rvalid latency in cycles (1..4)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
lb_waddr  in  ADDR_W  write byte address
lb_wdata  in  DATA_W  write data
lb_wen  in  1  write request
lb_wstrb  in  DATA_W/8  byte enables
lb_wready  out  1  write accept
lb_raddr  in  ADDR_W  read byte address
lb_ren  in  1  read request
lb_rdata  out  DATA_W  read data
lb_rvalid  out  1  read data valid
hw_in  in  CH_N*DATA_W  hardware update values, channel i at [i*DATA_W +: DATA_W]
hw_upd  in  CH_N  per-channel hardware update enable
wlock  in  CH_N  per-channel bus-write lock
val_out  out  CH_N*DATA_W  current register values
wstrb_out  out  CH_N  1-cycle pulse after an accepted, unlocked write to the channel
rstrb_out  out  CH_N  1-cycle pulse after a read of the channel

Behaviour:
- Reset: val_out=RESET_VAL, lb_rdata=0, lb_rvalid=0, lb_wready=0, wstrb_out=0, rstrb_out=0. The read pipeline is flushed; a read in flight at reset is dropped with no rvalid.
- lb_wready=1 every cycle after reset. A write is accepted in any cycle with lb_wen=1.
- Decode: hit when addr>=BASE_ADDR, (addr-BASE_ADDR) is a multiple of STRIDE, and index<CH_N. Anything else is unmapped: writes are ignored, reads return 0 with normal rvalid timing.
- Byte mask M = lb_wstrb expanded to bits. Next value on a write hit, unlocked:
  - RW/RC: (v&~M)|(d&M)
  - W1C: v&~(d&M)
  - W1S: v|(d&M)
  - W1T: v^(d&M)
- Register updates at the posedge following the lb_wen cycle. A write with wlock=1 leaves the value unchanged and produces no wstrb_out pulse.
- hw_upd[i]=1 loads hw_in slice on the next edge.
- Same cycle, same channel: an unlocked bus write has priority over hw_upd. A locked write loses to hw_upd.
- Read: lb_ren at cycle t samples the value before any same-cycle update. lb_rdata/lb_rvalid are valid exactly READ_LAT cycles later; lb_rvalid is a 1-cycle pulse. Back-to-back reads, one per cycle, are fully pipelined. lb_rdata holds its last value when rvalid=0.
- RC channel: a read clears the register at the edge after lb_ren. If hw_upd is asserted in the same cycle, hw_upd wins so the event is not lost. A same-cycle bus write wins over the clear.
- wstrb_out[i] and rstrb_out[i] are registered and assert in cycle t+1 for a request at cycle t. Read and write to different (or the same) channels in one cycle are both serviced.

Test Plan:
- Reset, CH_N=4, RESET_VAL ch1=0x00ffff00 -> read 0x4 returns 0x00ffff00 at t+READ_LAT; val_out ch0=0.
- RW ch0: write 0xdeadbeef, then 0x66778899 with strb 0b0110 -> val_out ch0=0xde7788ef, read-back matches.
- W1C ch2: hw_upd with 0x0000000f, then write 0x00000005 -> value 0x0000000a. W1S write 0x100 -> 0x10a. W1T ch3 written 0x1 twice -> 1 then 0.
- Priority: write 0x666 and hw_upd 0x777 same cycle on RW ch0 -> 0x666. With wlock=1, write 0x666 -> value unchanged (0x777 if hw_upd) and no wstrb_out pulse.
- RC ch1, READ_LAT=3: value 0x55, read -> rdata 0x55 exactly 3 cycles later, next read 0. Read plus same-cycle hw_upd 0x9 -> next read 0x9.
- Strobes and unmapped: read/write 0x4 -> rstrb_out[1]/wstrb_out[1] high for exactly one cycle at t+1. Read 0x40 or 0x2 -> rdata 0 with rvalid, no strobes. Reset asserted mid-read -> no rvalid.

Source files
------------

// File: rtl/lb_reg_array.sv
// Bank of CH_N control/status registers on the local bus, with per-channel write
// modes, a hardware update port, write locks, access strobes and a pipelined read path.
module lb_reg_array #(
  parameter int unsigned              ADDR_W    = 16,
  parameter int unsigned              DATA_W    = 32,
  parameter int unsigned              CH_N      = 4,
  parameter int unsigned              BASE_ADDR = 0,
  parameter int unsigned              STRIDE    = 4,
  parameter logic [3*CH_N-1:0]        MODE      = '0,
  parameter logic [CH_N*DATA_W-1:0]   RESET_VAL = '0,
  parameter int unsigned              READ_LAT  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        lb_waddr,
  input  logic [DATA_W-1:0]        lb_wdata,
  input  logic                     lb_wen,
  input  logic [DATA_W/8-1:0]      lb_wstrb,
  output logic                     lb_wready,
  input  logic [ADDR_W-1:0]        lb_raddr,
  input  logic                     lb_ren,
  output logic [DATA_W-1:0]        lb_rdata,
  output logic                     lb_rvalid,
  input  logic [CH_N*DATA_W-1:0]   hw_in,
  input  logic [CH_N-1:0]          hw_upd,
  input  logic [CH_N-1:0]          wlock,
  output logic [CH_N*DATA_W-1:0]   val_out,
  output logic [CH_N-1:0]          wstrb_out,
  output logic [CH_N-1:0]          rstrb_out
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned SH     = $clog2(STRIDE);
  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] M_W1C = 3'd1;
  localparam logic [MODE_W-1:0] M_W1S = 3'd2;
  localparam logic [MODE_W-1:0] M_W1T = 3'd3;
  localparam logic [MODE_W-1:0] M_RC  = 3'd4;

  logic [ADDR_W-1:0]      woff, roff, widx, ridx;
  logic                   whit, rhit;
  logic [DATA_W-1:0]      wmask, wbits, rd_mux;
  logic [CH_N-1:0]        wr_sel, rd_sel, wr_ok;
  logic [CH_N*DATA_W-1:0] val_q, val_d;
  logic [DATA_W-1:0]      pipe_data [READ_LAT];
  logic [READ_LAT-1:0]    pipe_vld;

  // Address decode: aligned to STRIDE, above BASE_ADDR, and below CH_N channels
  always_comb begin
    woff = lb_waddr - ADDR_W'(BASE_ADDR);
    roff = lb_raddr - ADDR_W'(BASE_ADDR);
    widx = woff >> SH;
    ridx = roff >> SH;
    whit = (lb_waddr >= ADDR_W'(BASE_ADDR)) &&
           ((woff & ADDR_W'(STRIDE - 1)) == '0) && (widx < ADDR_W'(CH_N));
    rhit = (lb_raddr >= ADDR_W'(BASE_ADDR)) &&
           ((roff & ADDR_W'(STRIDE - 1)) == '0) && (ridx < ADDR_W'(CH_N));
  end

  always_comb begin
    wmask = '0;
    for (int b = 0; b < int'(STRB_W); b++) begin
      wmask[b*8 +: 8] = {8{lb_wstrb[b]}};
    end
    wbits = lb_wdata & wmask;
  end

  always_comb begin
    wr_sel = '0;
    rd_sel = '0;
    rd_mux = '0;
    for (int i = 0; i < int'(CH_N); i++) begin
      wr_sel[i] = lb_wen && whit && (widx == ADDR_W'(i));
      rd_sel[i] = lb_ren && rhit && (ridx == ADDR_W'(i));
      if (rhit && (ridx == ADDR_W'(i))) begin
        rd_mux = val_q[i*DATA_W +: DATA_W];
      end
    end
    wr_ok = wr_sel & ~wlock;
  end

  // Next value: unlocked bus write, then hardware update, then clear-on-read
  always_comb begin : next_val
    logic [DATA_W-1:0] cur;
    logic [DATA_W-1:0] nxt;
    logic [MODE_W-1:0] mode;
    val_d = val_q;
    cur   = '0;
    nxt   = '0;
    mode  = '0;
    for (int i = 0; i < int'(CH_N); i++) begin
      cur  = val_q[i*DATA_W +: DATA_W];
      mode = MODE[i*MODE_W +: MODE_W];
      if (wr_ok[i]) begin
        case (mode)
          M_W1C:   nxt = cur & ~wbits;
          M_W1S:   nxt = cur | wbits;
          M_W1T:   nxt = cur ^ wbits;
          default: nxt = (cur & ~wmask) | wbits;
        endcase
      end else if (hw_upd[i]) begin
        nxt = hw_in[i*DATA_W +: DATA_W];
      end else if (rd_sel[i] && (mode == M_RC)) begin
        nxt = '0;
      end else begin
        nxt = cur;
      end
      val_d[i*DATA_W +: DATA_W] = nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q     <= RESET_VAL;
      lb_wready <= 1'b0;
      wstrb_out <= '0;
      rstrb_out <= '0;
    end else begin
      val_q     <= val_d;
      lb_wready <= 1'b1;
      wstrb_out <= wr_ok;
      rstrb_out <= rd_sel;
    end
  end

  // Read pipeline; data stages only load behind a valid so rdata holds between reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld <= '0;
      for (int k = 0; k < int'(READ_LAT); k++) begin
        pipe_data[k] <= '0;
      end
    end else begin
      pipe_vld[0] <= lb_ren;
      if (lb_ren) begin
        pipe_data[0] <= rd_mux;
      end
      for (int k = 1; k < int'(READ_LAT); k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        if (pipe_vld[k-1]) begin
          pipe_data[k] <= pipe_data[k-1];
        end
      end
    end
  end

  assign val_out   = val_q;
  assign lb_rdata  = pipe_data[READ_LAT-1];
  assign lb_rvalid = pipe_vld[READ_LAT-1];

endmodule

// File: tb/tb_lb_reg_array.sv
// Directed bench for lb_reg_array: five channels (RW, RC, W1C, W1T, W1S), read latency 3.
module tb_lb_reg_array;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CH_N   = 5;
  localparam int unsigned LAT    = 3;
  localparam logic [3*CH_N-1:0]      MODE_P  = 15'b010_011_001_100_000;
  localparam logic [CH_N*DATA_W-1:0] RST_P   = {32'h0, 32'h0, 32'h0, 32'h00ffff00, 32'h0};

  logic                   clk = 1'b0;
  logic                   rst;
  logic [ADDR_W-1:0]      lb_waddr, lb_raddr;
  logic [DATA_W-1:0]      lb_wdata;
  logic                   lb_wen, lb_ren;
  logic [DATA_W/8-1:0]    lb_wstrb;
  logic                   lb_wready;
  logic [DATA_W-1:0]      lb_rdata;
  logic                   lb_rvalid;
  logic [CH_N*DATA_W-1:0] hw_in;
  logic [CH_N-1:0]        hw_upd, wlock;
  logic [CH_N*DATA_W-1:0] val_out;
  logic [CH_N-1:0]        wstrb_out, rstrb_out;

  int checks = 0;
  int errors = 0;

  lb_reg_array #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CH_N(CH_N), .BASE_ADDR(0), .STRIDE(4),
    .MODE(MODE_P), .RESET_VAL(RST_P), .READ_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .lb_waddr(lb_waddr), .lb_wdata(lb_wdata), .lb_wen(lb_wen), .lb_wstrb(lb_wstrb),
    .lb_wready(lb_wready),
    .lb_raddr(lb_raddr), .lb_ren(lb_ren), .lb_rdata(lb_rdata), .lb_rvalid(lb_rvalid),
    .hw_in(hw_in), .hw_upd(hw_upd), .wlock(wlock),
    .val_out(val_out), .wstrb_out(wstrb_out), .rstrb_out(rstrb_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic        ren;
    logic [4:0]  hw;
    logic [31:0] hwd;
    logic [15:0] addr;
    logic [31:0] wd;
    logic [3:0]  strb;
    logic [4:0]  lock;
    int          ch;
    logic [31:0] ev;
    logic [4:0]  ews;
    logic [4:0]  ers;
    logic [31:0] erd;
  } vec_t;

  vec_t vecs [25];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    lb_wen = 1'b0; lb_ren = 1'b0; hw_upd = '0; wlock = '0;
  endtask

  task automatic run_vec(input int n, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", n);
    lb_wen = v.wen; lb_ren = v.ren; lb_waddr = v.addr; lb_raddr = v.addr;
    lb_wdata = v.wd; lb_wstrb = v.strb; wlock = v.lock; hw_upd = v.hw;
    hw_in = {CH_N{v.hwd}};
    tick();
    idle();
    chk({tag, " val"}, 160'(val_out[v.ch*32 +: 32]), 160'(v.ev));
    chk({tag, " wstrb"}, 160'(wstrb_out), 160'(v.ews));
    chk({tag, " rstrb"}, 160'(rstrb_out), 160'(v.ers));
    chk({tag, " rvalid_early"}, 160'(lb_rvalid), 160'(0));
    tick();
    chk({tag, " strobes_drop"}, 160'({wstrb_out, rstrb_out}), 160'(0));
    if (v.ren) begin
      tick();
      chk({tag, " rvalid"}, 160'(lb_rvalid), 160'(1));
      chk({tag, " rdata"}, 160'(lb_rdata), 160'(v.erd));
    end
  endtask

  initial begin
    //            wen  ren  hw       hwd           addr    wd            strb  lock     ch ev            ews      ers      erd
    vecs[0]  = '{1'b0,1'b1,5'b00000,32'h0,        16'h0,  32'h0,        4'h0,5'b00000,1, 32'h0,        5'b00000,5'b00010,32'h00ffff00};
    vecs[1]  = '{1'b0,1'b1,5'b00000,32'h0,        16'h0,  32'h0,        4'h0,5'b00000,0, 32'h0,        5'b00000,5'b00001,32'h0};
    vecs[1].addr = 16'h0;
    vecs[0].addr = 16'h4;
    vecs[2]  = '{1'b1,1'b0,5'b00000,32'h0,        16'h0,  32'hdeadbeef, 4'hf,5'b00000,0, 32'hdeadbeef, 5'b00001,5'b00000,32'h0};
    vecs[3]  = '{1'b1,1'b0,5'b00000,32'h0,        16'h0,  32'h66778899, 4'h6,5'b00000,0, 32'hde7788ef, 5'b00001,5'b00000,32'h0};
    vecs[4]  = '{1'b0,1'b1,5'b00000,32'h0,        16'h0,  32'h0,        4'h0,5'b00000,0, 32'hde7788ef, 5'b00000,5'b00001,32'hde7788ef};
    vecs[5]  = '{1'b0,1'b0,5'b00100,32'h0000000f, 16'h0,  32'h0,        4'h0,5'b00000,2, 32'h0000000f, 5'b00000,5'b00000,32'h0};
    vecs[6]  = '{1'b1,1'b0,5'b00000,32'h0,        16'h8,  32'h00000005, 4'hf,5'b00000,2, 32'h0000000a, 5'b00100,5'b00000,32'h0};
    vecs[7]  = '{1'b0,1'b0,5'b10000,32'h0000000a, 16'h0,  32'h0,        4'h0,5'b00000,4, 32'h0000000a, 5'b00000,5'b00000,32'h0};
    vecs[8]  = '{1'b1,1'b0,5'b00000,32'h0,        16'h10, 32'h00000100, 4'hf,5'b00000,4, 32'h0000010a, 5'b10000,5'b00000,32'h0};
    vecs[9]  = '{1'b1,1'b0,5'b00000,32'h0,        16'hc,  32'h00000001, 4'hf,5'b00000,3, 32'h00000001, 5'b01000,5'b00000,32'h0};
    vecs[10] = '{1'b1,1'b0,5'b00000,32'h0,        16'hc,  32'h00000001, 4'hf,5'b00000,3, 32'h00000000, 5'b01000,5'b00000,32'h0};
    vecs[11] = '{1'b1,1'b0,5'b00001,32'h00000777, 16'h0,  32'h00000666, 4'hf,5'b00000,0, 32'h00000666, 5'b00001,5'b00000,32'h0};
    vecs[12] = '{1'b1,1'b0,5'b00001,32'h00000777, 16'h0,  32'h00000123, 4'hf,5'b00001,0, 32'h00000777, 5'b00000,5'b00000,32'h0};
    vecs[13] = '{1'b1,1'b0,5'b00000,32'h0,        16'h0,  32'h00000999, 4'hf,5'b00001,0, 32'h00000777, 5'b00000,5'b00000,32'h0};
    vecs[14] = '{1'b0,1'b0,5'b00010,32'h00000055, 16'h0,  32'h0,        4'h0,5'b00000,1, 32'h00000055, 5'b00000,5'b00000,32'h0};
    vecs[15] = '{1'b0,1'b1,5'b00000,32'h0,        16'h4,  32'h0,        4'h0,5'b00000,1, 32'h0,        5'b00000,5'b00010,32'h00000055};
    vecs[16] = '{1'b0,1'b1,5'b00000,32'h0,        16'h4,  32'h0,        4'h0,5'b00000,1, 32'h0,        5'b00000,5'b00010,32'h0};
    vecs[17] = '{1'b0,1'b1,5'b00010,32'h00000009, 16'h4,  32'h0,        4'h0,5'b00000,1, 32'h00000009, 5'b00000,5'b00010,32'h0};
    vecs[18] = '{1'b0,1'b1,5'b00000,32'h0,        16'h4,  32'h0,        4'h0,5'b00000,1, 32'h0,        5'b00000,5'b00010,32'h00000009};
    vecs[19] = '{1'b0,1'b1,5'b00000,32'h0,        16'h40, 32'h0,        4'h0,5'b00000,0, 32'h00000777, 5'b00000,5'b00000,32'h0};
    vecs[20] = '{1'b0,1'b1,5'b00000,32'h0,        16'h2,  32'h0,        4'h0,5'b00000,0, 32'h00000777, 5'b00000,5'b00000,32'h0};
    vecs[21] = '{1'b1,1'b0,5'b00000,32'h0,        16'h2,  32'hffffffff, 4'hf,5'b00000,0, 32'h00000777, 5'b00000,5'b00000,32'h0};
    vecs[22] = '{1'b1,1'b0,5'b00000,32'h0,        16'h4,  32'h00001234, 4'hf,5'b00000,1, 32'h00001234, 5'b00010,5'b00000,32'h0};
    vecs[23] = '{1'b1,1'b1,5'b00000,32'h0,        16'h4,  32'h0000abcd, 4'hf,5'b00000,1, 32'h0000abcd, 5'b00010,5'b00010,32'h00001234};
    vecs[24] = '{1'b1,1'b0,5'b00000,32'h0,        16'h14, 32'h0000ffff, 4'hf,5'b00000,4, 32'h0000010a, 5'b00000,5'b00000,32'h0};

    // Reset state
    rst = 1'b1;
    lb_waddr = '0; lb_raddr = '0; lb_wdata = '0; lb_wstrb = '0; hw_in = '0;
    idle();
    tick();
    tick();
    chk("rst val_out", val_out, RST_P);
    chk("rst rdata", 160'(lb_rdata), 160'(0));
    chk("rst rvalid", 160'(lb_rvalid), 160'(0));
    chk("rst wready", 160'(lb_wready), 160'(0));
    chk("rst strobes", 160'({wstrb_out, rstrb_out}), 160'(0));
    rst = 1'b0;
    tick();
    chk("wready after rst", 160'(lb_wready), 160'(1));

    for (int n = 0; n < 25; n++) begin
      run_vec(n, vecs[n]);
    end

    // Back-to-back reads: one result per cycle, then rdata holds
    lb_ren = 1'b1; lb_raddr = 16'h0;
    tick();
    chk("b2b rstrb0", 160'(rstrb_out), 160'(5'b00001));
    lb_raddr = 16'h10;
    tick();
    chk("b2b rstrb1", 160'(rstrb_out), 160'(5'b10000));
    lb_raddr = 16'h8;
    tick();
    lb_ren = 1'b0;
    chk("b2b rstrb2", 160'(rstrb_out), 160'(5'b00100));
    chk("b2b v0", 160'({lb_rvalid, lb_rdata}), 160'({1'b1, 32'h00000777}));
    tick();
    chk("b2b v1", 160'({lb_rvalid, lb_rdata}), 160'({1'b1, 32'h0000010a}));
    tick();
    chk("b2b v2", 160'({lb_rvalid, lb_rdata}), 160'({1'b1, 32'h0000000a}));
    tick();
    chk("b2b hold", 160'({lb_rvalid, lb_rdata}), 160'({1'b0, 32'h0000000a}));

    // Reset asserted while a read is in flight drops it
    lb_ren = 1'b1; lb_raddr = 16'h0;
    tick();
    lb_ren = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst val_out", val_out, RST_P);
    chk("midrst rvalid", 160'(lb_rvalid), 160'(0));
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("midrst no_rvalid%0d", c), 160'(lb_rvalid), 160'(0));
    end
    chk("midrst wready", 160'(lb_wready), 160'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
